dbb_outstanding_limiter: RTL
============================

Name: dbb_outstanding_limiter

Overview:
- Sits between the NVDLA DBB master port and the axi2mem slave, on the AW, AR and W channels.
- Registers AW/AR requests in one slice per channel.
- Caps outstanding read and write bursts. Enforces AW-before-W ordering, since axi2mem needs the address before any write data.
- Observes R/B completions (pass-through, not driven) to retire bursts.

Parameters:
ID_WIDTH, 8, AXI ID width of AW/AR/B/R
ADDR_WIDTH, 32, AXI address width
LEN_WIDTH, 4, DBB burst length field width (beats-1)
MAX_RD_OUT, 4, max read bursts accepted and not yet retired (>=1)
MAX_WR_OUT, 4, max write bursts accepted and not yet retired (>=1)
CW, $clog2(MAX+1) per counter, derived, not overridable

Ports:
clk  in  1  core clock, all logic on posedge
rst  in  1  synchronous active-high reset
s_aw_valid/s_aw_ready  in/out  1/1  AW from DBB
s_aw_addr/s_aw_id/s_aw_len  in  ADDR_WIDTH/ID_WIDTH/LEN_WIDTH  AW payload
s_ar_valid/s_ar_ready  in/out  1/1  AR from DBB
s_ar_addr/s_ar_id/s_ar_len  in  ADDR_WIDTH/ID_WIDTH/LEN_WIDTH  AR payload
s_w_valid/s_w_ready/s_w_last  in/out/in  1/1/1  W handshake from DBB (data/strb bypass block)
m_aw_valid/m_aw_ready, m_aw_addr/id/len  out/in, out  AW to axi2mem
m_ar_valid/m_ar_ready, m_ar_addr/id/len  out/in, out  AR to axi2mem
m_w_valid/m_w_ready  out/in  1/1  gated W to axi2mem
mon_r_valid/mon_r_ready/mon_r_last  in  1 each  R channel observation
mon_b_valid/mon_b_ready  in  1 each  B channel observation
rd_out_o  out  CW  current outstanding read count
wr_out_o  out  CW  current outstanding write count
err_o  out  1  sticky protocol error
stat_rd_stall_o/stat_wr_stall_o  out  32/32  stall counters (see Optional Feature)

Behaviour:
- Reset (rst=1 at posedge): slices empty, m_aw_valid=m_ar_valid=0, all counters=0, err_o=0, stat outputs=0. Reset mid-burst drops slice contents; bursts in flight are forgotten.
- AR slice, 1 entry:
  - s_ar_ready = (!full || m_ar_ready) && (rd_out < MAX_RD_OUT).
  - On s_ar handshake, load the payload; m_ar_valid=1 from the next cycle.
  - Entry clears on m_ar handshake unless reloaded in the same cycle, which gives 1 burst/cycle throughput.
  - Payload is held stable while m_ar_valid && !m_ar_ready.
  - Latency s→m: 1 cycle.
- AW slice: identical, using wr_out and MAX_WR_OUT.
- rd_out:
  - +1 on s_ar handshake; -1 on mon_r_valid&mon_r_ready&mon_r_last.
  - Both in one cycle: unchanged.
  - Count includes bursts still sitting in the slice.
- wr_out: +1 on s_aw handshake; -1 on mon_b_valid&mon_b_ready; same simultaneous rule.
- Limit check uses the registered count. A retirement in the same cycle does not unblock acceptance until the next cycle.
- W gating:
  - w_pend counter, width CW: +1 on m_aw handshake; -1 on m_w_valid&m_w_ready&s_w_last.
  - m_w_valid = s_w_valid && (w_pend!=0); s_w_ready = m_w_ready && (w_pend!=0).
  - w_pend=0 blocks W even if m_aw handshakes the same cycle.
  - Simultaneous +1/-1 leaves w_pend unchanged.
- Errors:
  - Retirement with count==0 sets err_o; the count saturates at 0.
  - w_last beat with w_pend==0 is impossible by gating; no check.
  - err_o clears only on rst.
- No combinational path from m_aw_valid/m_ar_valid to s_*_valid. s_*_ready depends combinationally on m_*_ready.

Optional Feature:
DBB_LIMIT_STATS_EN
- Defined: stat_rd_stall_o increments each cycle s_ar_valid=1 and rd_out==MAX_RD_OUT. stat_wr_stall_o does the same for AW with wr_out==MAX_WR_OUT. Both are 32-bit, saturate at 32'hFFFFFFFF, and reset to 0.
- Undefined: both outputs tied to 0, no counter flops.

Test Plan:
- Single read (len=3, addr 0x1000): s_ar_valid 1 cycle, m_ar_ready=1 → m_ar_valid high exactly the next cycle with addr 0x1000/len 3. rd_out_o 0→1, back to 0 the cycle after the 4th R beat with mon_r_last.
- Read limit: 5 back-to-back ARs, MAX_RD_OUT=4, no R → s_ar_ready low after the 4th accept. One R last retire → 5th AR accepted the next cycle, not the same cycle.
- W-before-AW: s_w_valid=1 with no AW for 5 cycles → m_w_valid=0, s_w_ready=0. AW issued → W passes from the cycle after the m_aw handshake; a 2-beat burst completes and w_pend returns to 0.
- Backpressure: m_ar_ready=0 for 3 cycles with the slice full → m_ar payload stable, s_ar_ready=0. m_ar_ready=1 with new s_ar_valid → pipelined accept, no bubble.
- Underflow: mon_b handshake with wr_out=0 → err_o=1 next cycle, wr_out_o stays 0. Sticky until rst. Sync reset mid-burst zeros all counters and m_*_valid.
- Stats (macro defined, MAX_WR_OUT=1): hold a second AW for 10 cycles with no B → stat_wr_stall_o=10. Macro undefined → stays 0.

Source files
------------

// File: rtl/dbb_outstanding_limiter.sv
// Outstanding-burst limiter between the DBB master and axi2mem: AW/AR register slices, read/write burst caps, AW-before-W gating.
// Optional stall statistics are compiled in with `define DBB_LIMIT_STATS_EN.
module dbb_outstanding_limiter #(
  parameter int ID_WIDTH   = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  parameter int MAX_RD_OUT = 4,
  parameter int MAX_WR_OUT = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              s_aw_valid,
  output logic                              s_aw_ready,
  input  logic [ADDR_WIDTH-1:0]             s_aw_addr,
  input  logic [ID_WIDTH-1:0]               s_aw_id,
  input  logic [LEN_WIDTH-1:0]              s_aw_len,
  input  logic                              s_ar_valid,
  output logic                              s_ar_ready,
  input  logic [ADDR_WIDTH-1:0]             s_ar_addr,
  input  logic [ID_WIDTH-1:0]               s_ar_id,
  input  logic [LEN_WIDTH-1:0]              s_ar_len,
  input  logic                              s_w_valid,
  output logic                              s_w_ready,
  input  logic                              s_w_last,
  output logic                              m_aw_valid,
  input  logic                              m_aw_ready,
  output logic [ADDR_WIDTH-1:0]             m_aw_addr,
  output logic [ID_WIDTH-1:0]               m_aw_id,
  output logic [LEN_WIDTH-1:0]              m_aw_len,
  output logic                              m_ar_valid,
  input  logic                              m_ar_ready,
  output logic [ADDR_WIDTH-1:0]             m_ar_addr,
  output logic [ID_WIDTH-1:0]               m_ar_id,
  output logic [LEN_WIDTH-1:0]              m_ar_len,
  output logic                              m_w_valid,
  input  logic                              m_w_ready,
  input  logic                              mon_r_valid,
  input  logic                              mon_r_ready,
  input  logic                              mon_r_last,
  input  logic                              mon_b_valid,
  input  logic                              mon_b_ready,
  output logic [$clog2(MAX_RD_OUT+1)-1:0]   rd_out_o,
  output logic [$clog2(MAX_WR_OUT+1)-1:0]   wr_out_o,
  output logic                              err_o,
  output logic [31:0]                       stat_rd_stall_o,
  output logic [31:0]                       stat_wr_stall_o
);
  localparam int CW_RD = $clog2(MAX_RD_OUT+1);
  localparam int CW_WR = $clog2(MAX_WR_OUT+1);

  logic                  ar_full_q, ar_full_d, aw_full_q, aw_full_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d, aw_addr_q, aw_addr_d;
  logic [ID_WIDTH-1:0]   ar_id_q, ar_id_d, aw_id_q, aw_id_d;
  logic [LEN_WIDTH-1:0]  ar_len_q, ar_len_d, aw_len_q, aw_len_d;
  logic [CW_RD-1:0]      rd_out_q, rd_out_d;
  logic [CW_WR-1:0]      wr_out_q, wr_out_d, w_pend_q, w_pend_d;
  logic                  err_q, err_d;
  logic                  s_ar_hs, m_ar_hs, s_aw_hs, m_aw_hs, rd_ret, wr_ret, w_done;

  // Acceptance is gated by the registered counts, so a retirement only unblocks next cycle.
  assign s_ar_ready = (!ar_full_q || m_ar_ready) && (rd_out_q < CW_RD'(MAX_RD_OUT));
  assign s_aw_ready = (!aw_full_q || m_aw_ready) && (wr_out_q < CW_WR'(MAX_WR_OUT));
  assign s_ar_hs    = s_ar_valid && s_ar_ready;
  assign s_aw_hs    = s_aw_valid && s_aw_ready;
  assign m_ar_hs    = ar_full_q && m_ar_ready;
  assign m_aw_hs    = aw_full_q && m_aw_ready;
  assign rd_ret     = mon_r_valid && mon_r_ready && mon_r_last;
  assign wr_ret     = mon_b_valid && mon_b_ready;

  assign m_w_valid  = s_w_valid && (w_pend_q != '0);
  assign s_w_ready  = m_w_ready && (w_pend_q != '0);
  assign w_done     = m_w_valid && m_w_ready && s_w_last;

  always_comb begin
    ar_full_d = ar_full_q;
    ar_addr_d = ar_addr_q;
    ar_id_d   = ar_id_q;
    ar_len_d  = ar_len_q;
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    aw_id_d   = aw_id_q;
    aw_len_d  = aw_len_q;
    if (s_ar_hs) begin
      ar_full_d = 1'b1;
      ar_addr_d = s_ar_addr;
      ar_id_d   = s_ar_id;
      ar_len_d  = s_ar_len;
    end else if (m_ar_hs) begin
      ar_full_d = 1'b0;
    end
    if (s_aw_hs) begin
      aw_full_d = 1'b1;
      aw_addr_d = s_aw_addr;
      aw_id_d   = s_aw_id;
      aw_len_d  = s_aw_len;
    end else if (m_aw_hs) begin
      aw_full_d = 1'b0;
    end
  end

  always_comb begin
    rd_out_d = rd_out_q;
    wr_out_d = wr_out_q;
    w_pend_d = w_pend_q;
    err_d    = err_q;
    // A retirement with nothing outstanding is a protocol error; the count holds at zero.
    if (rd_ret && rd_out_q == '0) err_d = 1'b1;
    if (wr_ret && wr_out_q == '0) err_d = 1'b1;
    if (s_ar_hs && !rd_ret) rd_out_d = rd_out_q + 1'b1;
    else if (!s_ar_hs && rd_ret && rd_out_q != '0) rd_out_d = rd_out_q - 1'b1;
    if (s_aw_hs && !wr_ret) wr_out_d = wr_out_q + 1'b1;
    else if (!s_aw_hs && wr_ret && wr_out_q != '0) wr_out_d = wr_out_q - 1'b1;
    if (m_aw_hs && !w_done) w_pend_d = w_pend_q + 1'b1;
    else if (!m_aw_hs && w_done) w_pend_d = w_pend_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_full_q <= 1'b0;
      ar_addr_q <= '0;
      ar_id_q   <= '0;
      ar_len_q  <= '0;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      aw_id_q   <= '0;
      aw_len_q  <= '0;
      rd_out_q  <= '0;
      wr_out_q  <= '0;
      w_pend_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      ar_full_q <= ar_full_d;
      ar_addr_q <= ar_addr_d;
      ar_id_q   <= ar_id_d;
      ar_len_q  <= ar_len_d;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      aw_id_q   <= aw_id_d;
      aw_len_q  <= aw_len_d;
      rd_out_q  <= rd_out_d;
      wr_out_q  <= wr_out_d;
      w_pend_q  <= w_pend_d;
      err_q     <= err_d;
    end
  end

  assign m_ar_valid = ar_full_q;
  assign m_ar_addr  = ar_addr_q;
  assign m_ar_id    = ar_id_q;
  assign m_ar_len   = ar_len_q;
  assign m_aw_valid = aw_full_q;
  assign m_aw_addr  = aw_addr_q;
  assign m_aw_id    = aw_id_q;
  assign m_aw_len   = aw_len_q;
  assign rd_out_o   = rd_out_q;
  assign wr_out_o   = wr_out_q;
  assign err_o      = err_q;

`ifdef DBB_LIMIT_STATS_EN
  logic [31:0] stat_rd_q, stat_rd_d, stat_wr_q, stat_wr_d;

  always_comb begin
    stat_rd_d = stat_rd_q;
    stat_wr_d = stat_wr_q;
    if (s_ar_valid && rd_out_q == CW_RD'(MAX_RD_OUT) && stat_rd_q != 32'hFFFF_FFFF)
      stat_rd_d = stat_rd_q + 32'd1;
    if (s_aw_valid && wr_out_q == CW_WR'(MAX_WR_OUT) && stat_wr_q != 32'hFFFF_FFFF)
      stat_wr_d = stat_wr_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rd_q <= '0;
      stat_wr_q <= '0;
    end else begin
      stat_rd_q <= stat_rd_d;
      stat_wr_q <= stat_wr_d;
    end
  end

  assign stat_rd_stall_o = stat_rd_q;
  assign stat_wr_stall_o = stat_wr_q;
`else
  assign stat_rd_stall_o = 32'd0;
  assign stat_wr_stall_o = 32'd0;
`endif
endmodule
